// File: rtl/rr_grant_encoder.sv
// Round-robin (or fixed-priority) request arbiter with a registered grant
// offered on a valid/ready handshake, as both a binary index and a one-hot vector.
module rr_grant_encoder #(
  parameter int N  = 16,
  parameter int RR = 1,
  parameter int W  = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         flush,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot
);

  // Handshake: a grant transfers on any rising edge where out_valid && out_ready.
  // While out_valid is high and out_ready is low, out_idx/out_onehot hold steady.
  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [W:0] N_W = (W + 1)'(N);

  logic         valid_q, valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] onehot_q, onehot_d;
  logic [W-1:0] ptr_q, ptr_d;

  state_t       state;
  logic         accept;
  logic         slot_free;
  logic [W:0]   inc;
  logic [W-1:0] next_base;
  logic [W-1:0] base;
  logic [W:0]   cand;
  logic         found;
  logic [W-1:0] win;

  assign state = valid_q ? HOLD : EMPTY;

  always_comb begin
    accept    = (state == HOLD) && out_ready;
    slot_free = (state == EMPTY) || out_ready;
    // Wide add so N-1 wraps to 0 cleanly for non-power-of-2 N.
    inc       = {1'b0, idx_q} + (W + 1)'(1);
    next_base = (inc == N_W) ? '0 : inc[W-1:0];
    base      = '0;
    if (RR != 0) begin
      base = accept ? next_base : ptr_q;
    end
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int off = 0; off < N; off++) begin
      cand = {1'b0, base} + (W + 1)'(off);
      if (cand >= N_W) begin
        cand = cand - N_W;
      end
      if (!found && req[cand[W-1:0]]) begin
        found = 1'b1;
        win   = cand[W-1:0];
      end
    end
  end

  always_comb begin
    valid_d  = valid_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    ptr_d    = ptr_q;
    if (flush) begin
      valid_d  = 1'b0;
      onehot_d = '0;
    end else if (slot_free) begin
      if (found) begin
        valid_d  = 1'b1;
        idx_d    = win;
        onehot_d = {{(N-1){1'b0}}, 1'b1} << win;
      end else begin
        valid_d  = 1'b0;
        onehot_d = '0;
      end
      if (accept && (RR != 0)) begin
        ptr_d = next_base;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      ptr_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      ptr_q    <= ptr_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_idx    = idx_q;
  assign out_onehot = onehot_q;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Directed bench for rr_grant_encoder: round-robin N=16, fixed-priority N=16
// and round-robin N=5 instances sharing one clock and reset.
module tb_rr_grant_encoder;

  logic        clk;
  logic        reset;

  logic [15:0] req_a;
  logic        flush_a, ready_a, valid_a;
  logic [3:0]  idx_a;
  logic [15:0] oh_a;

  logic [15:0] req_f;
  logic        flush_f, ready_f, valid_f;
  logic [3:0]  idx_f;
  logic [15:0] oh_f;

  logic [4:0]  req_n;
  logic        flush_n, ready_n, valid_n;
  logic [2:0]  idx_n;
  logic [4:0]  oh_n;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];
  logic [6:0] exp_ptr_q[$];

  rr_grant_encoder #(.N(16), .RR(1)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .flush(flush_a), .out_ready(ready_a),
    .out_valid(valid_a), .out_idx(idx_a), .out_onehot(oh_a)
  );

  rr_grant_encoder #(.N(16), .RR(0)) dut_f (
    .clk(clk), .reset(reset), .req(req_f), .flush(flush_f), .out_ready(ready_f),
    .out_valid(valid_f), .out_idx(idx_f), .out_onehot(oh_f)
  );

  rr_grant_encoder #(.N(5), .RR(1)) dut_n (
    .clk(clk), .reset(reset), .req(req_n), .flush(flush_n), .out_ready(ready_n),
    .out_valid(valid_n), .out_idx(idx_n), .out_onehot(oh_n)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pops one expected index from the scoreboard and compares a full grant.
  task automatic pop_grant(input string tag, input logic v, input logic [5:0] idx,
                           input logic [63:0] oh);
    logic [6:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=no_expectation expected=queued_grant", tag);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_valid"}, 64'(v), 64'd1);
    check({tag, "_idx"}, 64'(idx), 64'(e));
    check({tag, "_onehot"}, oh, 64'd1 << e);
  endtask

  initial begin
    int rot[8];
    int n5[4];
    int n5_ptr[4];
    rot    = '{1, 2, 15, 1, 2, 15, 1, 2};
    n5     = '{0, 4, 0, 4};
    n5_ptr = '{0, 1, 0, 1};

    reset   = 1'b1;
    req_a   = 16'hFFFF; flush_a = 1'b0; ready_a = 1'b1;
    req_f   = 16'h0000; flush_f = 1'b0; ready_f = 1'b1;
    req_n   = 5'b00000; flush_n = 1'b0; ready_n = 1'b1;

    // Reset held for two cycles
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_valid", 64'(valid_a), 64'd0);
      check("reset_idx", 64'(idx_a), 64'd0);
      check("reset_onehot", 64'(oh_a), 64'd0);
    end
    reset = 1'b0;

    // First grant after reset starts from index 0
    exp_q.push_back(7'd0);
    @(negedge clk);
    pop_grant("first", valid_a, 6'(idx_a), 64'(oh_a));
    req_a = 16'h8006;

    // Round-robin rotation
    for (int i = 0; i < 8; i++) exp_q.push_back(7'(rot[i]));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pop_grant("rot", valid_a, 6'(idx_a), 64'(oh_a));
    end

    // Stall on idx 2 while req changes, then accept and wrap
    ready_a = 1'b0;
    req_a   = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(valid_a), 64'd1);
      check("stall_idx", 64'(idx_a), 64'd2);
      check("stall_onehot", 64'(oh_a), 64'h0004);
    end
    ready_a = 1'b1;
    exp_q.push_back(7'd0);
    @(negedge clk);
    pop_grant("wrap", valid_a, 6'(idx_a), 64'(oh_a));
    req_a = 16'h8006;

    // Flush in HOLD idx 1 with accept pending: ptr must not advance
    exp_q.push_back(7'd1);
    @(negedge clk);
    pop_grant("pre_flush", valid_a, 6'(idx_a), 64'(oh_a));
    flush_a = 1'b1;
    @(negedge clk);
    check("flush_valid", 64'(valid_a), 64'd0);
    check("flush_onehot", 64'(oh_a), 64'd0);
    flush_a = 1'b0;
    exp_q.push_back(7'd1);
    @(negedge clk);
    pop_grant("flush_regrant", valid_a, 6'(idx_a), 64'(oh_a));

    // Accept with no requests drains to EMPTY and moves ptr to 2
    req_a = 16'h0000;
    @(negedge clk);
    check("drain_valid", 64'(valid_a), 64'd0);
    check("drain_onehot", 64'(oh_a), 64'd0);
    req_a   = 16'hFFFF;
    ready_a = 1'b0;
    exp_q.push_back(7'd2);
    @(negedge clk);
    pop_grant("ptr_base", valid_a, 6'(idx_a), 64'(oh_a));

    // Reset mid-HOLD with out_ready low
    reset = 1'b1;
    @(negedge clk);
    check("midreset_valid", 64'(valid_a), 64'd0);
    check("midreset_idx", 64'(idx_a), 64'd0);
    check("midreset_onehot", 64'(oh_a), 64'd0);
    reset = 1'b0;
    req_a = 16'h0000;

    // Fixed priority: lowest index always wins, ptr pinned at 0
    req_f = 16'h8006;
    for (int i = 0; i < 4; i++) exp_q.push_back(7'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pop_grant("fixed", valid_f, 6'(idx_f), 64'(oh_f));
      check("fixed_ptr", 64'(dut_f.ptr_q), 64'd0);
    end

    // Non-power-of-2 N=5 rotation and pointer wrap
    req_n = 5'b10001;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(7'(n5[i]));
      exp_ptr_q.push_back(7'(n5_ptr[i]));
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pop_grant("n5", valid_n, 6'(idx_n), 64'(oh_n));
      check("n5_ptr", 64'(dut_n.ptr_q), 64'(exp_ptr_q.pop_front()));
    end

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
